// File: rtl/sme_feeder.sv
// Host-side feeder for the SME character interface: buffers one string and one
// pattern, streams them on start, then returns the SME result as a done strobe.
module sme_feeder #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic       start,
    input  logic       send_str,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       timeout,
    output logic       err
);

    localparam int unsigned SLW = $clog2(STR_MAX + 1);
    localparam int unsigned PLW = $clog2(PAT_MAX + 1);
    localparam int unsigned SAW = $clog2(STR_MAX);
    localparam int unsigned PAW = $clog2(PAT_MAX);
    localparam int unsigned IW  = (SLW > PLW) ? SLW : PLW;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_STR = 3'd1;
    localparam logic [2:0] SEND_PAT = 3'd2;
    localparam logic [2:0] WAIT     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [7:0]     str_mem [STR_MAX];
    logic [7:0]     pat_mem [PAT_MAX];

    logic [2:0]     state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SLW-1:0] str_len_q, str_len_d, slen_q, slen_d;
    logic [PLW-1:0] pat_len_q, pat_len_d, plen_q, plen_d;
    logic           str_sent_q, str_sent_d;
    logic           busy_d, isstring_d, ispattern_d, done_d;
    logic           res_match_d, timeout_d, err_d;
    logic [7:0]     chardata_d;
    logic [4:0]     res_index_d;
    logic           wr_str_c, wr_pat_c, illegal_c;

    assign illegal_c = (pat_len_q == '0) ||
                       (send_str ? (str_len_q == '0) : !str_sent_q);

    // Outputs describe what is on the bus during the state being entered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        str_len_d   = str_len_q;
        pat_len_d   = pat_len_q;
        slen_d      = slen_q;
        plen_d      = plen_q;
        str_sent_d  = str_sent_q;
        chardata_d  = 8'h00;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        done_d      = 1'b0;
        res_match_d = res_match;
        res_index_d = res_index;
        timeout_d   = timeout;
        err_d       = err;
        wr_str_c    = 1'b0;
        wr_pat_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    str_len_d  = '0;
                    pat_len_d  = '0;
                    str_sent_d = 1'b0;
                end else if (start) begin
                    if (illegal_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        timeout_d   = 1'b0;
                        res_match_d = 1'b0;
                        res_index_d = 5'd0;
                    end else begin
                        slen_d = str_len_q;
                        plen_d = pat_len_q;
                        idx_d  = IW'(1);
                        if (send_str) begin
                            state_d    = SEND_STR;
                            chardata_d = str_mem[0];
                            isstring_d = 1'b1;
                        end else begin
                            state_d     = SEND_PAT;
                            chardata_d  = pat_mem[0];
                            ispattern_d = 1'b1;
                        end
                    end
                end else if (wr_en) begin
                    if (!wr_sel && str_len_q != SLW'(STR_MAX)) begin
                        wr_str_c  = 1'b1;
                        str_len_d = str_len_q + SLW'(1);
                    end else if (wr_sel && pat_len_q != PLW'(PAT_MAX)) begin
                        wr_pat_c  = 1'b1;
                        pat_len_d = pat_len_q + PLW'(1);
                    end
                end
            end
            SEND_STR: begin
                if (idx_q < IW'(slen_q)) begin
                    chardata_d = str_mem[idx_q[SAW-1:0]];
                    isstring_d = 1'b1;
                    idx_d      = idx_q + IW'(1);
                end else begin
                    state_d     = SEND_PAT;
                    str_sent_d  = 1'b1;
                    chardata_d  = pat_mem[0];
                    ispattern_d = 1'b1;
                    idx_d       = IW'(1);
                end
            end
            SEND_PAT: begin
                if (idx_q < IW'(plen_q)) begin
                    chardata_d  = pat_mem[idx_q[PAW-1:0]];
                    ispattern_d = 1'b1;
                    idx_d       = idx_q + IW'(1);
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (valid) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    res_match_d = match;
                    res_index_d = match_index;
                    timeout_d   = 1'b0;
                    err_d       = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    res_match_d = 1'b0;
                    res_index_d = 5'd0;
                    timeout_d   = 1'b1;
                    err_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            str_len_q  <= '0;
            pat_len_q  <= '0;
            slen_q     <= '0;
            plen_q     <= '0;
            str_sent_q <= 1'b0;
            busy       <= 1'b0;
            chardata   <= 8'h00;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            done       <= 1'b0;
            res_match  <= 1'b0;
            res_index  <= 5'd0;
            timeout    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            str_len_q  <= str_len_d;
            pat_len_q  <= pat_len_d;
            slen_q     <= slen_d;
            plen_q     <= plen_d;
            str_sent_q <= str_sent_d;
            busy       <= busy_d;
            chardata   <= chardata_d;
            isstring   <= isstring_d;
            ispattern  <= ispattern_d;
            done       <= done_d;
            res_match  <= res_match_d;
            res_index  <= res_index_d;
            timeout    <= timeout_d;
            err        <= err_d;
        end
    end

    // Buffer storage needs no reset; only the lengths define valid contents.
    always_ff @(posedge clk) begin
        if (wr_str_c) str_mem[str_len_q[SAW-1:0]] <= wr_data;
        if (wr_pat_c) pat_mem[pat_len_q[PAW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed self-checking bench for sme_feeder; the SME is emulated by driving
// valid/match/match_index by hand.
module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, wr_sel = 1'b0, clr = 1'b0, start = 1'b0, send_str = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       valid = 1'b0, match = 1'b0;
    logic [4:0] match_index = 5'd0;
    logic       busy, isstring, ispattern, done, res_match, timeout, err;
    logic [7:0] chardata;
    logic [4:0] res_index;

    int errors = 0;
    int checks = 0;

    sme_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr(clr), .start(start), .send_str(send_str), .busy(busy), .chardata(chardata),
        .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
        .match_index(match_index), .done(done), .res_match(res_match),
        .res_index(res_index), .timeout(timeout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write(input logic sel, input logic [7:0] ch);
        wr_en = 1'b1; wr_sel = sel; wr_data = ch;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) write(sel, s[i]);
    endtask

    task automatic launch(input logic s);
        start = 1'b1; send_str = s;
        step();
        start = 1'b0; send_str = 1'b0;
    endtask

    // Walks the stream from the first char cycle until the bus goes quiet.
    task automatic run_stream(input string es, input string ep);
        int si = 0, pi = 0, guard = 0;
        while ((isstring || ispattern) && guard < 200) begin
            check("busy_stream", busy, 1);
            if (isstring) begin
                check("str_char", chardata, es[si]);
                check("str_before_pat", pi, 0);
                si++;
            end else begin
                check("pat_char", chardata, ep[pi]);
                pi++;
            end
            guard++;
            step();
        end
        check("str_count", si, es.len());
        check("pat_count", pi, ep.len());
        check("bus_idle", {chardata, isstring, ispattern}, 0);
    endtask

    task automatic give_valid(input logic m, input logic [4:0] ix, input int delay);
        repeat (delay) step();
        check("no_early_done", done, 0);
        valid = 1'b1; match = m; match_index = ix;
        step();
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        check("done_valid", done, 1);
        check("res_match", res_match, m);
        check("res_index", res_index, ix);
        check("flags_valid", {timeout, err}, 0);
        check("busy_at_done", busy, 1);
        step();
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);
    endtask

    task automatic illegal_start(input logic s, input string tag);
        launch(s);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_nostream"}, {isstring, ispattern}, 0);
        step();
        check({tag, "_end"}, {done, busy}, 0);
        check({tag, "_err_hold"}, err, 1);
    endtask

    initial begin
        string ovf;
        int n;

        do_reset();
        check("reset_outputs", {busy, chardata, isstring, ispattern, done,
                                res_match, res_index, timeout, err}, 0);

        // No string ever sent and empty pattern
        illegal_start(1'b0, "ill_nostr");

        // Basic match
        load(1'b0, "hello world");
        load(1'b1, "wor");
        launch(1'b1);
        run_stream("hello world", "wor");
        give_valid(1'b1, 5'd6, 2);
        step();
        check("res_hold", {res_match, res_index}, {1'b1, 5'd6});

        // Timeout: pattern-only resend, no valid
        launch(1'b0);
        run_stream("", "wor");
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check("timeout_latency", n, 65);
        check("timeout_flag", timeout, 1);
        check("timeout_res", {res_match, res_index, err}, 0);
        step();
        check("timeout_end", {done, busy}, 0);

        // Pattern-only query with anchors
        do_reset();
        load(1'b0, "hello world");
        load(1'b1, "^wor");
        launch(1'b1);
        run_stream("hello world", "^wor");
        give_valid(1'b0, 5'd0, 1);
        launch(1'b0);
        run_stream("", "^wor");
        give_valid(1'b0, 5'd0, 0);

        // clr beats start in the same cycle
        clr = 1'b1; start = 1'b1; send_str = 1'b1;
        step();
        clr = 1'b0; start = 1'b0; send_str = 1'b0;
        check("clr_over_start", {busy, done, isstring}, 0);
        illegal_start(1'b0, "ill_after_clr");

        // Empty pattern
        load(1'b0, "abc");
        illegal_start(1'b1, "ill_nopat");

        // Overflow: 33rd write (0x7A) dropped
        clr = 1'b1; step(); clr = 1'b0;
        ovf = "";
        for (int i = 0; i < 32; i++) begin
            write(1'b0, 8'h41 + 8'(i));
            ovf = {ovf, string'(8'h41 + 8'(i))};
        end
        write(1'b0, 8'h7A);
        load(1'b1, "x");
        launch(1'b1);
        run_stream(ovf, "x");
        give_valid(1'b0, 5'd0, 1);

        // Reset in the 5th string cycle
        clr = 1'b1; step(); clr = 1'b0;
        load(1'b0, "abcdefgh");
        load(1'b1, "a");
        launch(1'b1);
        repeat (4) step();
        check("mid_5th_char", {isstring, chardata}, {1'b1, 8'h65});
        #2 reset = 1'b1;
        #1;
        check("mid_reset_outputs", {busy, chardata, isstring, ispattern, done,
                                    res_match, res_index, timeout, err}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        illegal_start(1'b0, "ill_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
